arb8_grant_ctrl: RTL
====================

# arb8_grant_ctrl

Eight-requester arbiter and grant sequencer built around the 8-input priority-encode function. It samples a level request vector and selects a single owner, using either fixed priority (highest index wins) or rotating priority. The grant is held until the owner releases it or a hold timeout expires. It sits between up to eight masters and one shared resource and provides a registered one-hot grant, a binary owner index and a valid flag.

## Interface
- `RR_EN`, default 1: 1 selects rotating priority, 0 selects fixed priority (index 7 highest).
- `MAX_HOLD`, default 16: maximum continuous grant cycles under contention; 0 disables the timeout; legal range 0..255.
- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  level request, bit i from master i.
- `gnt`  out  8  registered one-hot grant, or all zero.
- `gnt_idx`  out  3  binary index of the owner; meaningful only while `gnt_valid`=1.
- `gnt_valid`  out  1  high when `gnt` != 0.
- `preempt`  out  1  one-cycle pulse on the first cycle of a grant that was forced by timeout.

## Operation
- **States**
  - IDLE: no owner.
  - GRANT: one owner, hold counter `hcnt` (8 bits) running.
- **Search order**
  - Fixed mode: 7, 6, …, 0.
  - Rotating mode: `last`-1 down to 0, then 7 down to `last`.
  - `last` is the index of the most recent owner. After reset `last`=0, so the first search order equals fixed.
- **IDLE**
  - If `req` != 0: pick the winner, go to GRANT, load `gnt`, `gnt_idx` and `gnt_valid`, set `hcnt`=0, set `last`=winner.
  - Otherwise stay in IDLE with outputs zero.
- **GRANT, owner still requesting, no timeout** (`req[gnt_idx]`=1 and not (`MAX_HOLD`!=0 and `hcnt`==`MAX_HOLD`-1)):
  - Hold the grant and increment `hcnt`.
- **GRANT, release** (`req[gnt_idx]`=0):
  - Re-arbitrate over `req` in the same cycle.
  - If another request is pending, grant it at the next edge with no idle bubble, `hcnt`=0.
  - If no request is pending, go to IDLE and clear the outputs.
- **GRANT, timeout** (owner still requesting and `hcnt`==`MAX_HOLD`-1):
  - Re-arbitrate with the owner masked out.
  - If another request is pending, switch to it, pulse `preempt`, `hcnt`=0.
  - If no other request is pending, re-grant the same owner, reset `hcnt`, no `preempt`.
- **Requests during a grant:** a newly asserted request never preempts the owner, even in fixed mode with a higher index. It only competes at release or timeout.
- **Single-cycle request:** a request that is high for one cycle in IDLE still receives exactly one grant cycle, then is released.
- **Invariants:** `gnt` is always one-hot or zero; `gnt == (1 << gnt_idx)` whenever `gnt_valid`=1.

## Timing
- **Reset values:** `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `preempt`=0, state IDLE, `last`=0, `hcnt`=0.
- **Asynchronous reset:** asserting `rst_n` low clears everything immediately, including in the middle of a grant. After deassertion, the first possible grant appears one edge after `req` is sampled.
- **Latency:** a request sampled at edge k produces `gnt` visible after edge k.
- **Release latency:** the owner dropping `req` before edge k causes `gnt` to drop or switch at edge k.
- **Hold bound:** under contention, a single owner holds the grant for at most `MAX_HOLD` consecutive cycles.
- **Output registers:** all outputs are registered; there is no combinational path from `req` to any output.

## Structure
- **Shared package `arb_pkg`:** `N_REQ`=8, `IDX_W`=3, and the state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1.
- **Sub-module `arb_prio_pick`:** purely combinational.
  - Inputs: `req[7:0]`, `mask[7:0]`, `start[2:0]`, `rr`.
  - Outputs: `win_idx[2:0]` and `win_valid`.
  - Function: a masked, rotating priority encoder.
  - One instance serves IDLE arbitration, release and timeout re-arbitration; the mask is the owner one-hot on timeout, else 0.
- **Top level:** holds the FSM, `hcnt`, `last` and the output registers.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF, then release it. All outputs are 0 during reset, and `gnt`=8'h80, `gnt_idx`=7 one edge after release.
- **Fixed priority** (`RR_EN`=0): `req`=8'b0010_0100 gives `gnt`=8'h20, `gnt_idx`=5. Drop `req[5]`, and the next edge gives `gnt`=8'h04, `gnt_idx`=2 with no zero cycle. Drop `req[2]`, and `gnt_valid`=0.
- **Rotating with timeout** (`RR_EN`=1, `MAX_HOLD`=4, `req`=8'hFF held): owners cycle 7, 6, 5, …, 0, 7, each for exactly 4 cycles, with `preempt` high on the first cycle of every grant after the first.
- **Sole requester** (`MAX_HOLD`=4, `req`=8'h08 for 10 cycles): `gnt`=8'h08 continuously for 10 cycles, `preempt` never asserts, and `gnt` drops one edge after `req` clears.
- **No preemption by new requests:** owner 2 granted in fixed mode, then `req[7]` rises. `gnt` stays 8'h04 until `req[2]` drops, after which `gnt`=8'h80 at the next edge.
- **Reset mid-grant:** with `gnt`=8'h40, pulse `rst_n` low between edges. Outputs clear asynchronously, and after release the `req`=8'hC0 search starts at 7 (`last` was reset).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the eight-requester arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_t : arbiter FSM states (idle / one owner granted)
//   onehot  : index to one-hot grant vector
package arb_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/arb8_grant_ctrl_if.sv
// Request/grant bundle between the masters and the arbiter.
//   req       : level request, bit i from master i
//   gnt       : registered one-hot grant (or zero)
//   gnt_idx   : binary owner index, meaningful while gnt_valid
//   gnt_valid : grant present
//   preempt   : first cycle of a grant forced by hold timeout
// Modports: master = requester side, slave = arbiter side.
interface arb8_grant_ctrl_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             preempt;

   modport master (
      output req,
      input  gnt, gnt_idx, gnt_valid, preempt
   );

   modport slave (
      input  req,
      output gnt, gnt_idx, gnt_valid, preempt
   );

endinterface

// File: rtl/arb_prio_pick.sv
// Masked, rotating priority encoder (purely combinational).
//   req       : request vector
//   mask      : requests to ignore (current owner on timeout)
//   start     : index of most recent owner; search begins at start-1
//   rr        : 1 = rotating search, 0 = fixed (7 highest)
//   win_idx   : winning index
//   win_valid : a winner exists
module arb_prio_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] start,
   input  logic             rr,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_valid
);

   logic [N_REQ-1:0] cand;
   logic [IDX_W-1:0] base;
   logic [IDX_W-1:0] idx;

   assign cand = req & ~mask;
   // Fixed priority is the rotating search with start=0: 7, 6, ..., 0.
   assign base = rr ? start : '0;

   // Order visited: base-1, base-2, ..., base (modulo 8, descending).
   always_comb begin
      win_idx   = '0;
      win_valid = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = base - IDX_W'(k + 1);
         if (!win_valid && cand[idx]) begin
            win_idx   = idx;
            win_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb8_grant_ctrl.sv
// Eight-requester arbiter and grant sequencer.
//   RR_EN    : 1 rotating priority, 0 fixed priority (index 7 highest)
//   MAX_HOLD : max continuous grant cycles under contention, 0 = no limit
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of the request/grant bundle; all outputs registered
module arb8_grant_ctrl
   import arb_pkg::*;
#(
   parameter bit          RR_EN    = 1'b1,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   arb8_grant_ctrl_if.slave   bus
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             preempt_q, preempt_d;

   logic             owner_req;
   logic             timeout;
   logic [N_REQ-1:0] pick_mask;
   logic [IDX_W-1:0] win_idx;
   logic             win_valid;

   assign owner_req = bus.req[idx_q];
   assign timeout   = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);
   // Owner is excluded only when it is still requesting at timeout.
   assign pick_mask = (state_q == ST_GRANT && owner_req && timeout) ? gnt_q : '0;

   arb_prio_pick u_pick (
      .req       (bus.req),
      .mask      (pick_mask),
      .start     (last_q),
      .rr        (RR_EN),
      .win_idx   (win_idx),
      .win_valid (win_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hcnt_q    <= '0;
         last_q    <= '0;
         gnt_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      preempt_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_GRANT;
               gnt_d   = onehot(win_idx);
               idx_d   = win_idx;
               valid_d = 1'b1;
               hcnt_d  = '0;
               last_d  = win_idx;
            end else begin
               gnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
               hcnt_d  = '0;
            end
         end

         ST_GRANT: begin
            if (!owner_req) begin
               // Release: hand over without an idle bubble when possible.
               if (win_valid) begin
                  gnt_d  = onehot(win_idx);
                  idx_d  = win_idx;
                  hcnt_d = '0;
                  last_d = win_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  hcnt_d  = '0;
               end
            end else if (timeout) begin
               // Owner masked out; with no competitor it simply restarts.
               if (win_valid) begin
                  gnt_d     = onehot(win_idx);
                  idx_d     = win_idx;
                  last_d    = win_idx;
                  preempt_d = 1'b1;
               end
               hcnt_d = '0;
            end else begin
               hcnt_d = hcnt_q + 8'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.preempt   = preempt_q;

endmodule
